imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, registered immediate/target generator for the decode stage. Takes a raw
//  instruction field plus an extend mode and produces a full-width datapath operand:
//  zero-extend, sign-extend, branch offset, jump target, or upper-immediate.
//  The output sits behind a 2-entry skid buffer with valid/ready handshakes on both sides,
//  so decode stalls never drop or duplicate an operand.
// PARAMETERS
//  IN_W   26  width of in_imm; the JUMP mode uses the whole field
//  IMM_W  16  low in_imm bits used by ZERO/SIGN/BRANCH/LUI; legal range 1..IN_W
//  OUT_W  32  operand width; requires IN_W+2 <= OUT_W and IMM_W <= OUT_W
// PORTS
//  clock         in   1       single clock; all state changes on the rising edge
//  reset         in   1       asynchronous, active-high reset
//  in_valid      in   1       upstream presents in_imm/in_mode/in_pc
//  in_ready      out  1       block can accept; transfer when in_valid && in_ready
//  in_imm        in   IN_W    raw immediate / jump field
//  in_mode       in   3       0 ZERO, 1 SIGN, 2 BRANCH, 3 JUMP, 4 LUI, 5-7 illegal
//  in_pc         in   OUT_W   PC+4 of the instruction; used only by JUMP
//  out_valid     out  1       out_data/out_mode_err hold a result
//  out_ready     in   1       downstream accepts; transfer when out_valid && out_ready
//  out_data      out  OUT_W   extended operand
//  out_mode_err  out  1       result came from an illegal mode
// BEHAVIOUR
//  Let imm = in_imm[IMM_W-1:0] and s = imm[IMM_W-1].
//  - ZERO:   {(OUT_W-IMM_W) zeros, imm}
//  - SIGN:   {(OUT_W-IMM_W) copies of s, imm}
//  - BRANCH: SIGN result << 2, truncated to OUT_W
//  - JUMP:   {in_pc[OUT_W-1 : IN_W+2], in_imm, 2'b00}
//  - LUI:    {imm, (OUT_W-IMM_W) zeros}
//  - Illegal modes (5-7): out_data = 0, out_mode_err = 1. In all legal modes out_mode_err = 0.
//  - The result is computed combinationally from the input and written into the buffer on
//    acceptance. There is no further arithmetic.
//  Buffer FSM:
//  - States: EMPTY, ONE, TWO. Output is registered: out_valid = (state != EMPTY).
//  - in_ready = (state != TWO). in_ready depends only on state, never on out_ready.
//  - push = in_valid && in_ready; pop = out_valid && out_ready.
//  - EMPTY: push -> ONE.
//  - ONE: push&&!pop -> TWO; pop&&!push -> EMPTY; push&&pop -> ONE, new entry at head.
//  - TWO: pop -> ONE, second entry moves to head; push is impossible.
//  - Latency: an item accepted at edge N is visible on out_data after edge N, provided the
//    buffer is empty or is popped at edge N. Throughput is 1 item/cycle when out_ready=1.
//  - Strict FIFO order. No item is lost or duplicated.
//  - While out_valid && !out_ready, out_data and out_mode_err are held stable.
//  - in_* inputs are ignored when no push occurs.
//  Reset:
//  - Asserting reset at any time, including mid-transfer, clears state to EMPTY and discards
//    buffered entries.
//  - During reset: out_valid=0, out_data=0, out_mode_err=0, in_ready=0.
//  - in_ready rises on the first clock edge after reset deasserts.
// TESTING
//  1 SIGN, in_imm=0x0008000 -> 0xFFFF8000. ZERO, same input -> 0x00008000. err=0 for both.
//  2 BRANCH, imm=0xFFFF -> 0xFFFFFFFC. LUI, imm=0x1234 -> 0x12340000. BRANCH, imm=0x0010 -> 0x00000040.
//  3 JUMP, in_imm=0x0000010, in_pc=0xA0000004 -> 0xA0000040. Upper 4 PC bits kept.
//  4 Backpressure: out_ready=0, push A,B,C back-to-back -> in_ready falls after B; C held off.
//    Raise out_ready -> A, B, C emerge in order on consecutive cycles; out_data stable while stalled.
//  5 Streaming with in_valid=out_ready=1 for 8 items -> one output/cycle, 1-cycle latency,
//    state stays ONE.
//  6 in_mode=5 -> out_data=0, out_mode_err=1. Next item mode 1 -> err=0.
//    Assert reset with 2 entries held -> out_valid=0 immediately; no stale data after release.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate/target generator behind a 2-entry skid buffer
module imm_extend_pipe #(
    parameter int IN_W  = 26,
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_mode,
    input  logic [OUT_W-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_mode_err
);

    localparam logic [2:0] MODE_ZERO   = 3'd0;
    localparam logic [2:0] MODE_SIGN   = 3'd1;
    localparam logic [2:0] MODE_BRANCH = 3'd2;
    localparam logic [2:0] MODE_JUMP   = 3'd3;
    localparam logic [2:0] MODE_LUI    = 3'd4;

    // PC bits above the jump field survive into the jump target
    localparam logic [OUT_W-1:0] JMASK = {OUT_W{1'b1}} << (IN_W + 2);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state;
    logic               rdy_en;
    logic [OUT_W-1:0]   head_data, tail_data;
    logic               head_err, tail_err;

    logic [IMM_W-1:0]         imm;
    logic signed [IMM_W-1:0]  imm_s;
    logic signed [OUT_W-1:0]  sign_ext;
    logic [OUT_W-1:0]         zero_ext;
    logic [OUT_W-1:0]         new_data;
    logic                     new_err;
    logic                     push, pop;

    assign imm      = in_imm[IMM_W-1:0];
    assign imm_s    = imm;
    assign sign_ext = imm_s;
    assign zero_ext = OUT_W'(imm);

    always_comb begin
        new_data = '0;
        new_err  = 1'b0;
        case (in_mode)
            MODE_ZERO:   new_data = zero_ext;
            MODE_SIGN:   new_data = sign_ext;
            MODE_BRANCH: new_data = sign_ext << 2;
            MODE_JUMP:   new_data = (in_pc & JMASK) | OUT_W'({in_imm, 2'b00});
            MODE_LUI:    new_data = zero_ext << (OUT_W - IMM_W);
            default:     new_err  = 1'b1;
        endcase
    end

    // rdy_en keeps in_ready low until the first edge after reset releases
    assign in_ready     = rdy_en && (state != TWO);
    assign out_valid    = (state != EMPTY);
    assign out_data     = head_data;
    assign out_mode_err = head_err;
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            rdy_en    <= 1'b0;
            head_data <= '0;
            head_err  <= 1'b0;
            tail_data <= '0;
            tail_err  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_data <= new_data;
                        head_err  <= new_err;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_data <= new_data;
                        head_err  <= new_err;
                    end else if (push) begin
                        tail_data <= new_data;
                        tail_err  <= new_err;
                        state     <= TWO;
                    end else if (pop) begin
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_data <= tail_data;
                        head_err  <= tail_err;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [25:0] in_imm = '0;
    logic [2:0]  in_mode = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_mode_err;

    int checks = 0;
    int errors = 0;

    imm_extend_pipe #(.IN_W(26), .IMM_W(16), .OUT_W(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_mode_err(out_mode_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] mode, input logic [25:0] imm, input logic [31:0] pc);
        in_valid = 1'b1;
        in_mode  = mode;
        in_imm   = imm;
        in_pc    = pc;
    endtask

    // Push one item into an empty buffer with out_ready=1, check it, let it drain
    task automatic send_one(input string tag, input logic [2:0] mode, input logic [25:0] imm,
                            input logic [31:0] pc, input logic [31:0] exp_d, input logic exp_e);
        out_ready = 1'b1;
        drive(mode, imm, pc);
        @(negedge clock);
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_err"}, {31'b0, out_mode_err}, {31'b0, exp_e});
        @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_err", {31'b0, out_mode_err}, 32'd0);
        check("rst_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        check("rel_ready_low", {31'b0, in_ready}, 32'd0);
        @(negedge clock);
        check("rel_ready_high", {31'b0, in_ready}, 32'd1);

        send_one("sign", 3'd1, 26'h0008000, 32'h0, 32'hFFFF8000, 1'b0);
        send_one("zero", 3'd0, 26'h0008000, 32'h0, 32'h00008000, 1'b0);
        send_one("br_neg", 3'd2, 26'h000FFFF, 32'h0, 32'hFFFFFFFC, 1'b0);
        send_one("lui", 3'd4, 26'h0001234, 32'h0, 32'h12340000, 1'b0);
        send_one("br_pos", 3'd2, 26'h0000010, 32'h0, 32'h00000040, 1'b0);
        send_one("jump", 3'd3, 26'h0000010, 32'hA0000004, 32'hA0000040, 1'b0);
        send_one("zero_hi_ign", 3'd0, 26'h3FF1234, 32'h0, 32'h00001234, 1'b0);

        // Backpressure: A, B fill the buffer, C is held off
        out_ready = 1'b0;
        drive(3'd0, 26'h00000AA, 32'h0);
        @(negedge clock);
        check("bp_ready_one", {31'b0, in_ready}, 32'd1);
        drive(3'd0, 26'h00000BB, 32'h0);
        @(negedge clock);
        check("bp_ready_two", {31'b0, in_ready}, 32'd0);
        check("bp_head_a", out_data, 32'h000000AA);
        drive(3'd0, 26'h00000CC, 32'h0);
        @(negedge clock);
        check("bp_stall_ready", {31'b0, in_ready}, 32'd0);
        check("bp_stable_a", out_data, 32'h000000AA);
        check("bp_stall_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_out_b", out_data, 32'h000000BB);
        @(negedge clock);
        in_valid = 1'b0;
        check("bp_out_c", out_data, 32'h000000CC);
        @(negedge clock);
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        // Streaming: one item per cycle, 1-cycle latency, ready never drops
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(3'd0, 26'(i * 32'h111), 32'h0);
            @(negedge clock);
            check($sformatf("st_data%0d", i), out_data, 32'(i * 32'h111));
            check($sformatf("st_ready%0d", i), {31'b0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("st_drained", {31'b0, out_valid}, 32'd0);

        send_one("illegal5", 3'd5, 26'h000FFFF, 32'hFFFFFFFF, 32'h0, 1'b1);
        send_one("illegal7", 3'd7, 26'h0001234, 32'h0, 32'h0, 1'b1);
        send_one("after_ill", 3'd1, 26'h0007FFF, 32'h0, 32'h00007FFF, 1'b0);

        // Reset with two entries held
        out_ready = 1'b0;
        drive(3'd4, 26'h000ABCD, 32'h0);
        @(negedge clock);
        drive(3'd4, 26'h0001111, 32'h0);
        @(negedge clock);
        in_valid = 1'b0;
        check("pre_rst_two", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("post_rst_valid", {31'b0, out_valid}, 32'd0);
        check("post_rst_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clock);
        check("post_rst_stale", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
